// File: rtl/coef_bank_ctrl.sv
// Double-buffered 32-tap complex coefficient bank: host writes a shadow copy, swap on a convolver sample boundary.
// Optional shadow readback port enabled by defining COEF_READBACK_EN.
module coef_bank_ctrl (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [17:0]       wr_real,
  input  logic [17:0]       wr_imag,
  input  logic              commit_req,
  input  logic              sample_strobe,
`ifdef COEF_READBACK_EN
  input  logic [4:0]        rd_addr,
  output logic [17:0]       rd_real,
  output logic [17:0]       rd_imag,
`endif
  output logic              commit_ack,
  output logic [31:0][17:0] coef_real,
  output logic [31:0][17:0] coef_imag,
  output logic              busy,
  output logic              wr_err,
  output logic [31:0]       shadow_mask
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t             state;
  logic [31:0][17:0]  shadow_real;
  logic [31:0][17:0]  shadow_imag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      commit_ack  <= 1'b0;
      wr_err      <= 1'b0;
      shadow_mask <= '0;
      shadow_real <= '0;
      shadow_imag <= '0;
      // Pass-through: unity (max positive) on tap 0, everything else zero
      coef_real    <= '0;
      coef_real[0] <= 18'h1FFFF;
      coef_imag    <= '0;
    end else begin
      commit_ack <= 1'b0;
      wr_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            shadow_real[wr_addr] <= wr_real;
            shadow_imag[wr_addr] <= wr_imag;
            shadow_mask[wr_addr] <= 1'b1;
          end
          if (commit_req) begin
            state <= PENDING;
            busy  <= 1'b1;
          end
        end
        PENDING: begin
          if (wr_en) wr_err <= 1'b1;
          // Whole bank loads in one edge so the convolver never sees a mixed set
          if (sample_strobe) begin
            coef_real   <= shadow_real;
            coef_imag   <= shadow_imag;
            shadow_mask <= '0;
            commit_ack  <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COEF_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_real <= '0;
      rd_imag <= '0;
    end else begin
      rd_real <= shadow_real[rd_addr];
      rd_imag <= shadow_imag[rd_addr];
    end
  end
`endif

endmodule

// File: doc/coef_bank_ctrl.md
COEF_BANK_CTRL -- requirements
Module: coef_bank_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL have ports: wr_en input 1, shadow write strobe; wr_addr input 5, tap index 0..31; wr_real input 18, tap real part; wr_imag input 18, tap imag part.
REQ-003 SHALL have ports: commit_req input 1, request shadow-to-active swap; sample_strobe input 1, convolver sample boundary; commit_ack output 1, one-cycle pulse on swap.
REQ-004 SHALL have ports: coef_real output [31:0][18], coef_imag output [31:0][18], active bank driving convolver coefficient inputs.
REQ-005 SHALL have ports: busy output 1, high while a commit is pending; wr_err output 1, one-cycle pulse on dropped write; shadow_mask output 32, taps written since last swap.

Function
REQ-006 SHALL hold two banks of 32 complex 18-bit taps: shadow (host-written) and active (driven to outputs).
REQ-007 SHALL implement states IDLE and PENDING; busy SHALL be high exactly in PENDING.
REQ-008 In IDLE with wr_en high, shadow[wr_addr] SHALL take {wr_real, wr_imag} at the clock edge and shadow_mask[wr_addr] SHALL set.
REQ-009 In IDLE with commit_req high, state SHALL go to PENDING at the next edge; a wr_en in the same cycle SHALL be accepted and included in the commit.
REQ-010 sample_strobe in IDLE, including in the same cycle as commit_req, SHALL have no effect.
REQ-011 In PENDING with sample_strobe high, all 64 active words SHALL load from shadow at that edge, state SHALL return to IDLE, commit_ack SHALL be high for the following cycle, and shadow_mask SHALL clear.
REQ-012 commit_ack SHALL be asserted in the first cycle the new coefficients are visible on coef_real/coef_imag; no partial bank update SHALL ever be visible.
REQ-013 In PENDING, wr_en SHALL be dropped (shadow unchanged) and wr_err SHALL pulse the next cycle.
REQ-014 commit_req in PENDING SHALL be ignored.
REQ-015 A write to an already-set shadow_mask bit SHALL overwrite the tap without error.
REQ-016 Shadow SHALL be retained across a swap; an immediate second commit SHALL re-load identical contents.
REQ-017 All outputs SHALL be registered; coef outputs SHALL change only on a swap or reset.

Reset
REQ-018 On reset, state SHALL be IDLE; busy, commit_ack, wr_err SHALL be 0; shadow_mask SHALL be 0.
REQ-019 On reset, active bank SHALL be pass-through: coef_real[0]=18'h1FFFF, all other coef_real and all coef_imag 0.
REQ-020 On reset, all shadow taps SHALL be 0.
REQ-021 Reset in PENDING SHALL abort the commit with no commit_ack and no active update beyond REQ-019.
REQ-022 Reset SHALL override all other inputs in the same cycle.

Configuration
REQ-023 With COEF_READBACK_EN defined, SHALL add rd_addr input 5, rd_real output 18, and rd_imag output 18, returning shadow[rd_addr] registered one cycle after rd_addr is presented, reading 0 during and after reset until written.
REQ-024 Without COEF_READBACK_EN, those ports and the read mux SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-025 Reset release -> coef_real[0]=0x1FFFF, other taps 0, busy=0, shadow_mask=0.
REQ-026 Write taps 0..31 with real=addr*4, imag=-addr; commit_req; strobe 3 cycles later -> outputs unchanged until the swap edge, then commit_ack for one cycle, coef_real[5]=20, coef_imag[5]=-5, shadow_mask=0.
REQ-027 commit_req then wr_en addr 7 while PENDING -> wr_err one cycle, shadow[7] unchanged, busy stays 1 until strobe.
REQ-028 wr_en addr 3 (value 0x00123) with commit_req and sample_strobe in the same IDLE cycle -> state PENDING, no swap that cycle; next strobe swaps with coef_real[3]=0x00123.
REQ-029 commit_req, reset asserted during PENDING, then strobe -> no commit_ack, pass-through bank, shadow zeroed.
REQ-030 (COEF_READBACK_EN) write addr 9 = (0x3FFFF, 0x00001), set rd_addr=9 -> rd_real=0x3FFFF, rd_imag=1 one cycle later.
